// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit, its instruction BRAM, the
// core controller and the decode stage.
//   slave  : the fetch unit (drives IMEM_*, IF_ID_*, IF_* status/counters)
//   master : the surrounding core / testbench (drives control, decode and BRAM data)
// Clock and reset are kept as plain ports on the fetch unit.
interface instruction_fetch_unit_if #(
  parameter int IMEM_AW = 10,
  parameter int CNT_W   = 32
);
  // core control
  logic               Start;
  logic [31:0]        Core_StartPC;
  logic               Halt;
  // decode stage
  logic               ID_stall;
  logic               ID_PCSrc;
  logic [31:0]        ID_new_PC;
  // instruction BRAM
  logic [IMEM_AW-1:0] IMEM_Addr;
  logic               IMEM_En;
  logic [31:0]        IMEM_ReadData;
  // IF/ID register view and status
  logic [31:0]        IF_ID_Instruction;
  logic [31:0]        IF_ID_PC4;
  logic               IF_Running;
  logic [CNT_W-1:0]   IF_FetchCount;
  logic [CNT_W-1:0]   IF_StallCount;
  logic [CNT_W-1:0]   IF_RedirectCount;

  modport slave (
    input  Start, Core_StartPC, Halt, ID_stall, ID_PCSrc, ID_new_PC, IMEM_ReadData,
    output IMEM_Addr, IMEM_En, IF_ID_Instruction, IF_ID_PC4, IF_Running,
           IF_FetchCount, IF_StallCount, IF_RedirectCount
  );

  modport master (
    output Start, Core_StartPC, Halt, ID_stall, ID_PCSrc, ID_new_PC, IMEM_ReadData,
    input  IMEM_Addr, IMEM_En, IF_ID_Instruction, IF_ID_PC4, IF_Running,
           IF_FetchCount, IF_StallCount, IF_RedirectCount
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage of one core.
// The instruction BRAM's registered output is the IF/ID pipeline register, so
// the next fetch address is computed combinationally and a redirect costs no
// bubble. Stalls freeze the BRAM output by dropping IMEM_En.
// Ports:
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : instruction_fetch_unit_if.slave
//              in : Start, Core_StartPC, Halt, ID_stall, ID_PCSrc, ID_new_PC, IMEM_ReadData
//              out: IMEM_Addr, IMEM_En, IF_ID_Instruction, IF_ID_PC4, IF_Running,
//                   IF_FetchCount, IF_StallCount, IF_RedirectCount

// Saturating event counter; clr wins over inc.
module ifu_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

module instruction_fetch_unit #(
  parameter int          IMEM_AW  = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                      Clk,
  input  logic                      Rst,
  instruction_fetch_unit_if.slave   bus
);
  localparam int NCNT = 3;  // fetch, stall, redirect

  typedef enum logic {IDLE, RUN} st_e;

  st_e                st_q, st_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;  // byte address of the word on IMEM_ReadData
  logic [31:0]        nxt;
  logic [IMEM_AW-1:0] addr;
  logic               en, start_acc, redirect, stall_evt;

  logic [NCNT-1:0]             cnt_inc;
  logic [NCNT-1:0][CNT_W-1:0]  cnt_val;

  always_comb begin
    st_d       = st_q;
    fetch_pc_d = fetch_pc_q;
    nxt        = fetch_pc_q;
    addr       = fetch_pc_q[IMEM_AW+1:2];
    en         = 1'b0;
    start_acc  = 1'b0;
    redirect   = 1'b0;
    stall_evt  = 1'b0;
    case (st_q)
      IDLE: begin
        addr = bus.Core_StartPC[IMEM_AW+1:2];
        if (bus.Start) begin
          en         = 1'b1;
          start_acc  = 1'b1;
          st_d       = RUN;
          fetch_pc_d = bus.Core_StartPC & ~32'h3;
        end
      end
      RUN: begin
        // Halt beats stall beats redirect; a stalled decode may hold stale
        // branch operands, so its PCSrc is not trusted.
        if (bus.Halt) begin
          st_d = IDLE;
        end else if (bus.ID_stall) begin
          stall_evt = 1'b1;
        end else if (bus.ID_PCSrc) begin
          nxt      = bus.ID_new_PC & ~32'h3;
          en       = 1'b1;
          redirect = 1'b1;
        end else begin
          nxt = fetch_pc_q + 32'd4;
          en  = 1'b1;
        end
        addr = nxt[IMEM_AW+1:2];
        if (en) fetch_pc_d = nxt;
      end
      default: ;
    endcase
    // Reset must never let the BRAM move or a counter tick.
    if (Rst) begin
      en        = 1'b0;
      start_acc = 1'b0;
      redirect  = 1'b0;
      stall_evt = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      st_q       <= IDLE;
      fetch_pc_q <= '0;
    end else begin
      st_q       <= st_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // IDLE never increments: en in IDLE only comes from Start, which clears.
  assign cnt_inc[0] = (st_q == RUN) && en;
  assign cnt_inc[1] = (st_q == RUN) && stall_evt;
  assign cnt_inc[2] = (st_q == RUN) && redirect;

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    ifu_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk_i (Clk),
      .clr_i (Rst | start_acc),
      .inc_i (cnt_inc[g]),
      .cnt_o (cnt_val[g])
    );
  end

  assign bus.IMEM_Addr         = addr;
  assign bus.IMEM_En           = en;
  assign bus.IF_ID_Instruction = (st_q == RUN) ? bus.IMEM_ReadData : NOP_WORD;
  assign bus.IF_ID_PC4         = fetch_pc_q + 32'd4;
  assign bus.IF_Running        = (st_q == RUN);
  assign bus.IF_FetchCount     = cnt_val[0];
  assign bus.IF_StallCount     = cnt_val[1];
  assign bus.IF_RedirectCount  = cnt_val[2];
endmodule
